// File: rtl/ibex_pkg.sv
`default_nettype none
// ============================================================================
// Package : ibex_pkg
// Shared multiply/divide operator encoding and issue-FSM state type.
// Rev     : 1.0
// ============================================================================
package ibex_pkg;

   typedef enum logic [1:0] {
      MD_OP_MULL = 2'd0,
      MD_OP_MULH = 2'd1,
      MD_OP_DIV  = 2'd2,
      MD_OP_REM  = 2'd3
   } md_op_e;

   typedef enum logic [2:0] {
      MD_ISSUE_IDLE  = 3'd0,
      MD_ISSUE_MULT  = 3'd1,
      MD_ISSUE_DIV   = 3'd2,
      MD_ISSUE_DRAIN = 3'd3,
      MD_ISSUE_RESP  = 3'd4
   } md_issue_fsm_e;

   // Longest legitimate divide is 37 cycles; the watchdog must sit above it.
   localparam int unsigned MD_ISSUE_MIN_CYCLES = 40;

endpackage
`default_nettype wire

// File: rtl/ibex_multdiv_issue.sv
`default_nettype none
// ============================================================================
// Module : ibex_multdiv_issue
// Issues one MUL/DIV request to the multdiv responder and registers the result.
// Rev    : 1.0
// ============================================================================
module ibex_multdiv_issue
   import ibex_pkg::*;
#(
   parameter int unsigned MaxCycles = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  md_op_e      req_operator_i,
   input  logic [1:0]  req_signed_mode_i,
   input  logic [31:0] req_op_a_i,
   input  logic [31:0] req_op_b_i,
   input  logic [4:0]  req_rd_i,
   input  logic        flush_i,
   output logic        md_mult_en_o,
   output logic        md_div_en_o,
   output md_op_e      md_operator_o,
   output logic [1:0]  md_signed_mode_o,
   output logic [31:0] md_op_a_o,
   output logic [31:0] md_op_b_o,
   input  logic [31:0] md_result_i,
   input  logic        md_valid_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_result_o,
   output logic [4:0]  rsp_rd_o,
   output logic        busy_o,
   output logic        err_o
);

   localparam int unsigned        c_CNT_W    = $clog2(MaxCycles + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MaxCycles - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(MaxCycles);

   md_issue_fsm_e      r_state;
   logic [c_CNT_W-1:0] r_cnt;
   md_op_e             r_op;
   logic [1:0]         r_sm;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [4:0]         r_rd;
   logic [31:0]        r_result;
   logic               r_rsp_valid;

   logic w_accept;
   logic w_busy_md;
   logic w_timeout;
   logic w_op_div;

   // Gating with rst_ni keeps every output low while reset is held.
   assign req_ready_o = rst_ni & ~flush_i &
                        ((r_state == MD_ISSUE_IDLE) |
                         ((r_state == MD_ISSUE_RESP) & rsp_ready_i));
   assign w_accept    = req_valid_i & req_ready_o;
   assign w_busy_md   = (r_state == MD_ISSUE_MULT) | (r_state == MD_ISSUE_DIV) |
                        (r_state == MD_ISSUE_DRAIN);
   assign w_timeout   = w_busy_md & ~md_valid_i & (r_cnt == c_CNT_LAST);
   assign w_op_div    = (r_op == MD_OP_DIV) | (r_op == MD_OP_REM);

   assign md_mult_en_o     = (r_state == MD_ISSUE_MULT) | ((r_state == MD_ISSUE_DRAIN) & ~w_op_div);
   assign md_div_en_o      = (r_state == MD_ISSUE_DIV)  | ((r_state == MD_ISSUE_DRAIN) &  w_op_div);
   assign md_operator_o    = r_op;
   assign md_signed_mode_o = r_sm;
   assign md_op_a_o        = r_a;
   assign md_op_b_o        = r_b;
   assign rsp_valid_o      = r_rsp_valid;
   assign rsp_result_o     = r_result;
   assign rsp_rd_o         = r_rd;
   assign busy_o           = (r_state != MD_ISSUE_IDLE);
   assign err_o            = w_timeout;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= MD_ISSUE_IDLE;
         r_cnt       <= '0;
         r_op        <= MD_OP_MULL;
         r_sm        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_rd        <= '0;
         r_result    <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         case (r_state)
            MD_ISSUE_IDLE: ;
            MD_ISSUE_MULT, MD_ISSUE_DIV: begin
               // A completion coinciding with a flush is simply discarded.
               if (md_valid_i) begin
                  if (flush_i) begin
                     r_state <= MD_ISSUE_IDLE;
                  end else begin
                     r_result    <= md_result_i;
                     r_rsp_valid <= 1'b1;
                     r_state     <= MD_ISSUE_RESP;
                  end
               end else if (w_timeout) begin
                  r_state <= MD_ISSUE_IDLE;
               end else if (flush_i) begin
                  r_state <= MD_ISSUE_DRAIN;
               end
               if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + 1'b1;
            end
            MD_ISSUE_DRAIN: begin
               if (md_valid_i || w_timeout) r_state <= MD_ISSUE_IDLE;
               if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + 1'b1;
            end
            MD_ISSUE_RESP: begin
               if (flush_i || rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= MD_ISSUE_IDLE;
               end
            end
            default: r_state <= MD_ISSUE_IDLE;
         endcase

         // Accept overrides the RESP exit above to allow back-to-back issue.
         if (w_accept) begin
            r_op    <= req_operator_i;
            r_sm    <= req_signed_mode_i;
            r_a     <= req_op_a_i;
            r_b     <= req_op_b_i;
            r_rd    <= req_rd_i;
            r_cnt   <= '0;
            r_state <= ((req_operator_i == MD_OP_DIV) || (req_operator_i == MD_OP_REM)) ?
                       MD_ISSUE_DIV : MD_ISSUE_MULT;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ibex_multdiv_issue.sv
`default_nettype none
// ============================================================================
// Module : tb_ibex_multdiv_issue
// Self-checking bench with a multdiv responder model and reference arithmetic.
// Rev    : 1.0
// ============================================================================
module tb_ibex_multdiv_issue;
   import ibex_pkg::*;

   logic        clk_i  = 1'b0;
   logic        rst_ni = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   md_op_e      req_operator_i = MD_OP_MULL;
   logic [1:0]  req_signed_mode_i = 2'b00;
   logic [31:0] req_op_a_i = '0;
   logic [31:0] req_op_b_i = '0;
   logic [4:0]  req_rd_i = '0;
   logic        flush_i = 1'b0;
   logic        md_mult_en_o, md_div_en_o;
   md_op_e      md_operator_o;
   logic [1:0]  md_signed_mode_o;
   logic [31:0] md_op_a_o, md_op_b_o;
   logic [31:0] md_result_i = '0;
   logic        md_valid_i = 1'b0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b1;
   logic [31:0] rsp_result_o;
   logic [4:0]  rsp_rd_o;
   logic        busy_o, err_o;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit hang_mode = 1'b0;

   ibex_multdiv_issue #(.MaxCycles(64)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_operator_i(req_operator_i), .req_signed_mode_i(req_signed_mode_i),
      .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_rd_i(req_rd_i),
      .flush_i(flush_i),
      .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
      .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
      .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o),
      .md_result_i(md_result_i), .md_valid_i(md_valid_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_rd_o(rsp_rd_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Architectural result of an operation, plain arithmetic.
   function automatic logic [31:0] ref_result(md_op_e op, logic [1:0] sm,
                                              logic [31:0] a, logic [31:0] b);
      logic signed [32:0] ea, eb;
      logic signed [65:0] p;
      logic signed [31:0] sa, sb;
      logic [31:0] r;
      ea = {sm[0] & a[31], a};
      eb = {sm[1] & b[31], b};
      p  = ea * eb;
      sa = a;
      sb = b;
      case (op)
         MD_OP_MULL: r = p[31:0];
         MD_OP_MULH: r = p[63:32];
         default: begin
            if (b == 32'd0)
               r = (op == MD_OP_DIV) ? 32'hFFFF_FFFF : a;
            else if (sm == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               r = (op == MD_OP_DIV) ? a : 32'd0;
            else if (sm == 2'b11)
               r = (op == MD_OP_DIV) ? 32'(sa / sb) : 32'(sa % sb);
            else
               r = (op == MD_OP_DIV) ? a / b : a % b;
         end
      endcase
      return r;
   endfunction

   // Cycles from accept to rsp_valid_o.
   function automatic int ref_lat(md_op_e op, logic [31:0] b);
      case (op)
         MD_OP_MULL: return 4;
         MD_OP_MULH: return 5;
         default:    return (b == 32'd0) ? 3 : 38;
      endcase
   endfunction

   // Responder: md_valid_i on the Nth consecutive enable cycle.
   int rcnt = 0;
   always @(negedge clk_i) begin
      if (!rst_ni || !(md_mult_en_o || md_div_en_o)) begin
         rcnt = 0;
         md_valid_i = 1'b0;
      end else begin
         rcnt = rcnt + 1;
         if (!hang_mode && rcnt == ref_lat(md_operator_o, md_op_b_o) - 1) begin
            md_valid_i  = 1'b1;
            md_result_i = ref_result(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
         end else begin
            md_valid_i  = 1'b0;
            md_result_i = $urandom;
         end
      end
   end

   // Presents a request and returns the cycle in which it was accepted.
   task automatic issue(input md_op_e op, input logic [1:0] sm, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, output int n_acc);
      bit ok;
      ok = 1'b0;
      n_acc = -1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b1; req_operator_i = op; req_signed_mode_i = sm;
      req_op_a_i = a; req_op_b_i = b; req_rd_i = rd;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (req_ready_o) begin ok = 1'b1; n_acc = cyc; break; end
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL accept: req_ready_o=%b required 1", req_ready_o); end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
   endtask

   // Waits for rsp_valid_o, tracking enables and operand stability.
   task automatic wait_rsp(input int n_acc, input md_op_e op, input logic [1:0] sm,
                           input logic [31:0] a, input logic [31:0] b,
                           output int men, output int den, output int lat,
                           output logic [31:0] res, output logic [4:0] rdo,
                           output bit got, output bit stable);
      men = 0; den = 0; lat = -1; res = '0; rdo = '0; got = 1'b0; stable = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (md_mult_en_o) men++;
         if (md_div_en_o) den++;
         if (md_mult_en_o && md_div_en_o) stable = 1'b0;
         if ((md_mult_en_o || md_div_en_o) &&
             (md_op_a_o !== a || md_op_b_o !== b || md_operator_o !== op || md_signed_mode_o !== sm))
            stable = 1'b0;
         if (rsp_valid_o) begin
            got = 1'b1; lat = cyc - n_acc; res = rsp_result_o; rdo = rsp_rd_o;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst_ni = 1'b0;
      #2;
      n_checks++;
      if ({req_ready_o, md_mult_en_o, md_div_en_o, rsp_valid_o, busy_o, err_o} !== 6'b0 ||
          md_op_a_o !== 0 || md_op_b_o !== 0 || rsp_result_o !== 0 || rsp_rd_o !== 0 ||
          md_signed_mode_o !== 0 || md_operator_o !== MD_OP_MULL) begin
         n_fail++; $display("FAIL reset_outputs: ready=%b busy=%b a=%h res=%h required all 0",
                            req_ready_o, busy_o, md_op_a_o, rsp_result_o);
      end
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle: ready=%b busy=%b required 1/0", req_ready_o, busy_o);
      end
   endtask

   task automatic test_mull();
      int n, men, den, lat; logic [31:0] res; logic [4:0] rdo; bit got, st;
      issue(MD_OP_MULL, 2'b11, 32'h0000_0003, 32'hFFFF_FFFE, 5'd5, n);
      wait_rsp(n, MD_OP_MULL, 2'b11, 32'h3, 32'hFFFF_FFFE, men, den, lat, res, rdo, got, st);
      n_checks++;
      if (!got || lat !== 4) begin n_fail++; $display("FAIL mull_latency: got %0d required 4", lat); end
      n_checks++;
      if (men !== 3 || den !== 0) begin n_fail++; $display("FAIL mull_enable: mult=%0d div=%0d required 3/0", men, den); end
      n_checks++;
      if (res !== 32'hFFFF_FFFA || rdo !== 5'd5) begin
         n_fail++; $display("FAIL mull_result: %h rd %0d required fffffffa rd 5", res, rdo);
      end
   endtask

   task automatic test_div();
      int n, men, den, lat; logic [31:0] res; logic [4:0] rdo; bit got, st;
      issue(MD_OP_DIV, 2'b00, 32'd100, 32'd7, 5'd9, n);
      wait_rsp(n, MD_OP_DIV, 2'b00, 32'd100, 32'd7, men, den, lat, res, rdo, got, st);
      n_checks++;
      if (!got || lat !== 38) begin n_fail++; $display("FAIL div_latency: got %0d required 38", lat); end
      n_checks++;
      if (den !== 37 || men !== 0) begin n_fail++; $display("FAIL div_enable: div=%0d mult=%0d required 37/0", den, men); end
      n_checks++;
      if (!st) begin n_fail++; $display("FAIL div_operands_stable: stable=%b required 1", st); end
      n_checks++;
      if (res !== 32'd14 || rdo !== 5'd9) begin n_fail++; $display("FAIL div_result: %0d rd %0d required 14 rd 9", res, rdo); end
   endtask

   task automatic test_flush_drain();
      int n, dd, idle_cyc; bit rv, rdy, busy_drain;
      issue(MD_OP_DIV, 2'b00, 32'd1000, 32'd3, 5'd3, n);
      repeat (4) @(posedge clk_i);
      #1 flush_i = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if (md_div_en_o !== 1'b1 || md_mult_en_o !== 1'b0 || req_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL flush_cycle: div_en=%b mult_en=%b ready=%b required 1/0/0",
                            md_div_en_o, md_mult_en_o, req_ready_o);
      end
      @(posedge clk_i); #1 flush_i = 1'b0;
      dd = 0; rv = 1'b0; rdy = 1'b0; idle_cyc = -1; busy_drain = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (rsp_valid_o) rv = 1'b1;
         if (!busy_o) begin idle_cyc = cyc; rdy = req_ready_o; break; end
         if (md_div_en_o) dd++;
      end
      n_checks++;
      if (dd !== 32) begin n_fail++; $display("FAIL drain_enable: div_en cycles %0d required 32", dd); end
      n_checks++;
      if (rv !== 1'b0) begin n_fail++; $display("FAIL drain_no_rsp: rsp_valid seen %b required 0", rv); end
      n_checks++;
      if (idle_cyc - n !== 38 || rdy !== 1'b1) begin
         n_fail++; $display("FAIL drain_exit: idle at +%0d ready=%b required +38 ready 1", idle_cyc - n, rdy);
      end
   endtask

   task automatic test_back_to_back();
      int n, men, den, lat; logic [31:0] res, hres, a, b, a2, b2; logic [4:0] rdo; bit got, st, held;
      a = $urandom; b = $urandom;
      a2 = $urandom; b2 = $urandom_range(1, 1000);
      rsp_ready_i = 1'b0;
      issue(MD_OP_MULL, 2'b00, a, b, 5'd7, n);
      wait_rsp(n, MD_OP_MULL, 2'b00, a, b, men, den, lat, hres, rdo, got, st);
      n_checks++;
      if (!got || hres !== ref_result(MD_OP_MULL, 2'b00, a, b) || rdo !== 5'd7) begin
         n_fail++; $display("FAIL b2b_first: %h rd %0d required %h rd 7", hres, rdo, ref_result(MD_OP_MULL, 2'b00, a, b));
      end
      req_valid_i = 1'b1; req_operator_i = MD_OP_REM; req_signed_mode_i = 2'b00;
      req_op_a_i = a2; req_op_b_i = b2; req_rd_i = 5'd12;
      held = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid_o !== 1'b1 || rsp_result_o !== hres || rsp_rd_o !== 5'd7 || req_ready_o !== 1'b0)
            held = 1'b0;
         @(posedge clk_i); #1;
         if (i < 3) @(negedge clk_i);
      end
      n_checks++;
      if (!held) begin n_fail++; $display("FAIL b2b_hold: stable=%b required 1", held); end
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL b2b_handshake: ready=%b rsp_valid=%b required 1/1", req_ready_o, rsp_valid_o);
      end
      n = cyc;
      @(posedge clk_i); #1 req_valid_i = 1'b0;
      wait_rsp(n, MD_OP_REM, 2'b00, a2, b2, men, den, lat, res, rdo, got, st);
      n_checks++;
      if (!got || lat !== 38 || res !== a2 % b2 || rdo !== 5'd12) begin
         n_fail++; $display("FAIL b2b_rem: %h lat %0d rd %0d required %h lat 38 rd 12", res, lat, rdo, a2 % b2);
      end
   endtask

   task automatic test_watchdog();
      int n, err_cyc, pulses; bit post_ok, rv;
      hang_mode = 1'b1;
      issue(MD_OP_DIV, 2'b11, 32'd55, 32'd5, 5'd1, n);
      err_cyc = -1; pulses = 0; post_ok = 1'b0; rv = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk_i);
         if (err_o) begin pulses++; if (err_cyc < 0) err_cyc = cyc; end
         if (rsp_valid_o) rv = 1'b1;
         if (err_cyc >= 0 && cyc == err_cyc + 1)
            post_ok = !busy_o && !md_div_en_o && !md_mult_en_o;
      end
      hang_mode = 1'b0;
      n_checks++;
      if (err_cyc - n !== 64 || pulses !== 1) begin
         n_fail++; $display("FAIL watchdog_pulse: at +%0d pulses %0d required +64 pulses 1", err_cyc - n, pulses);
      end
      n_checks++;
      if (!post_ok || rv) begin n_fail++; $display("FAIL watchdog_exit: idle_ok=%b rsp=%b required 1/0", post_ok, rv); end
   endtask

   task automatic test_reset_mid();
      int n, men, den, lat; logic [31:0] res; logic [4:0] rdo; bit got, st;
      issue(MD_OP_MULH, 2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 5'd20, n);
      #2 rst_ni = 1'b0;
      #1;
      n_checks++;
      if ({req_ready_o, md_mult_en_o, md_div_en_o, rsp_valid_o, busy_o, err_o} !== 6'b0 ||
          md_op_a_o !== 0 || md_op_b_o !== 0 || rsp_result_o !== 0 || rsp_rd_o !== 0) begin
         n_fail++; $display("FAIL reset_mid: busy=%b mult_en=%b a=%h rd=%0d required all 0",
                            busy_o, md_mult_en_o, md_op_a_o, rsp_rd_o);
      end
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      issue(MD_OP_MULL, 2'b00, 32'd1234, 32'd5678, 5'd2, n);
      wait_rsp(n, MD_OP_MULL, 2'b00, 32'd1234, 32'd5678, men, den, lat, res, rdo, got, st);
      n_checks++;
      if (!got || lat !== 4 || res !== 32'd7006652 || rdo !== 5'd2) begin
         n_fail++; $display("FAIL reset_then_mull: %0d lat %0d required 7006652 lat 4", res, lat);
      end
   endtask

   task automatic test_random();
      int n, men, den, lat, exp_en; logic [31:0] res, a, b; logic [4:0] rdo, rd;
      bit got, st; md_op_e op; logic [1:0] sm;
      for (int k = 0; k < 40; k++) begin
         op = md_op_e'($urandom_range(0, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if (k == 7) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; op = MD_OP_DIV; end
         sm = 2'($urandom_range(0, 3));
         if (op == MD_OP_DIV || op == MD_OP_REM) sm = sm[0] ? 2'b11 : 2'b00;
         rd = 5'($urandom);
         issue(op, sm, a, b, rd, n);
         wait_rsp(n, op, sm, a, b, men, den, lat, res, rdo, got, st);
         exp_en = ref_lat(op, b) - 1;
         n_checks++;
         if (!got || lat !== ref_lat(op, b) || res !== ref_result(op, sm, a, b) || rdo !== rd || !st ||
             (men + den) !== exp_en) begin
            n_fail++;
            $display("FAIL random[%0d] op=%0d: res %h lat %0d rd %0d en %0d stable %b required %h lat %0d rd %0d en %0d stable 1",
                     k, op, res, lat, rdo, men + den, st, ref_result(op, sm, a, b), ref_lat(op, b), rd, exp_en);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mull();
      test_div();
      test_flush_drain();
      test_back_to_back();
      test_watchdog();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
